// File: rtl/ppu_obj_pkg.sv
// Shared types and constants for the PPU OBJ (sprite) fetch path.
package ppu_obj_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TILE,
      FLAGS,
      LO,
      HI,
      PUSH
   } obj_fetch_state_t;

   // OAM attribute byte bit positions
   localparam int ATTR_PRIO  = 7;
   localparam int ATTR_YFLIP = 6;
   localparam int ATTR_XFLIP = 5;
   localparam int ATTR_PAL   = 4;

   // Byte offsets within a 4-byte OAM entry
   localparam logic [1:0] OAM_TILE_OFS  = 2'd2;
   localparam logic [1:0] OAM_FLAGS_OFS = 2'd3;

endpackage

// File: rtl/obj_slot_matcher.sv
// Per-slot hit detect: a sprite is due once the LCD X counter reaches its left edge.
// OAM X is offset by 8, so X=0 is fully off-screen and never hits.
module obj_slot_matcher (
   input  logic       obj_ena,
   input  logic       valid,
   input  logic       done,
   input  logic [7:0] slot_x,
   input  logic [7:0] x_pos,
   output logic       hit
);

   // 9-bit compare so x_pos+8 cannot wrap past 255
   assign hit = obj_ena & valid & ~done & (slot_x != 8'd0) &
                ({1'b0, slot_x} <= ({1'b0, x_pos} + 9'd8));

endmodule

// File: rtl/obj_fetch_engine.sv
// OBJ fetcher: picks the lowest-index hitting slot, reads its OAM tile/flags and
// two row bytes, then pushes 8 decoded pixels plus attributes into the OBJ FIFO.
//
// state | meaning
// IDLE  | waiting for a hit and a free memory port
// TILE  | reading OAM tile number
// FLAGS | reading OAM attribute byte
// LO    | reading low bit-plane of the sprite row
// HI    | reading high bit-plane of the sprite row
// PUSH  | offering 8 pixels to the OBJ FIFO
module obj_fetch_engine
   import ppu_obj_pkg::*;
#(
   parameter int          SLOTS     = 10,
   parameter logic [15:0] OAM_BASE  = 16'hFE00,
   parameter logic [15:0] VRAM_BASE = 16'h8000
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               tclk_in,
   input  logic [7:0]         x_in,
   input  logic               line_start_in,
   input  logic               obj_ena_in,
   input  logic               tall_mode_in,
   input  logic [SLOTS-1:0]   slot_valid_in,
   input  logic [SLOTS*8-1:0] slot_x_in,
   input  logic [SLOTS*6-1:0] slot_num_in,
   input  logic [SLOTS*4-1:0] slot_row_in,
   output logic               obj_pending_out,
   input  logic               mem_free_in,
   output logic [15:0]        addr_out,
   output logic               addr_valid_out,
   input  logic [7:0]         data_in,
   input  logic               data_valid_in,
   input  logic               fifo_ready_in,
   output logic               push_valid_out,
   output logic [15:0]        push_pixels_out,
   output logic               push_palette_out,
   output logic               push_priority_out
);

   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   obj_fetch_state_t state, state_nxt;

   logic [SLOTS-1:0] hit;
   logic [SLOTS-1:0] done_q;
   logic             any_hit;
   logic [IDX_W-1:0] sel_idx;
   logic [7:0]       sel_x;
   logic [5:0]       sel_num;
   logic [3:0]       sel_row;

   logic [IDX_W-1:0] win_q;
   logic [7:0]       x_q;
   logic [5:0]       num_q;
   logic [3:0]       row_q;
   logic [7:0]       tile_q;
   logic [7:4]       flags_q;
   logic [7:0]       lo_q;
   logic [7:0]       hi_q;

   logic [15:0]      oam_addr;
   logic [7:0]       tile_eff;
   logic [3:0]       row_eff;
   logic [15:0]      row_base;
   logic [15:0]      pix_raw;
   logic [15:0]      pix_clip;
   logic [4:0]       clip_sh;

   for (genvar i = 0; i < SLOTS; i++) begin : g_match
      obj_slot_matcher u_match (
         .obj_ena (obj_ena_in),
         .valid   (slot_valid_in[i]),
         .done    (done_q[i]),
         .slot_x  (slot_x_in[i*8 +: 8]),
         .x_pos   (x_in),
         .hit     (hit[i])
      );
   end

   // Priority encoder: lowest slot index wins, scanned high-to-low so the last write sticks
   always_comb begin
      any_hit = 1'b0;
      sel_idx = '0;
      sel_x   = '0;
      sel_num = '0;
      sel_row = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit = 1'b1;
            sel_idx = IDX_W'(i);
            sel_x   = slot_x_in[i*8 +: 8];
            sel_num = slot_num_in[i*6 +: 6];
            sel_row = slot_row_in[i*4 +: 4];
         end
      end
   end

   assign obj_pending_out = any_hit | (state != IDLE);

   // State register, advancing only on T-cycle enables
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)       state <= IDLE;
      else if (tclk_in) state <= state_nxt;
   end

   // Next-state logic; a new line aborts whatever is in flight
   always_comb begin
      state_nxt = state;
      if (line_start_in) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (any_hit && mem_free_in) state_nxt = TILE;
            TILE:    if (data_valid_in)          state_nxt = FLAGS;
            FLAGS:   if (data_valid_in)          state_nxt = LO;
            LO:      if (data_valid_in)          state_nxt = HI;
            HI:      if (data_valid_in)          state_nxt = PUSH;
            PUSH:    if (fifo_ready_in)          state_nxt = IDLE;
            default:                             state_nxt = IDLE;
         endcase
      end
   end

   // Winner capture on leaving IDLE, then one byte latched per completed read
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         win_q   <= '0;
         x_q     <= '0;
         num_q   <= '0;
         row_q   <= '0;
         tile_q  <= '0;
         flags_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
      end else if (tclk_in && !line_start_in) begin
         case (state)
            IDLE: if (any_hit && mem_free_in) begin
               win_q <= sel_idx;
               x_q   <= sel_x;
               num_q <= sel_num;
               row_q <= sel_row;
            end
            TILE:  if (data_valid_in) tile_q  <= data_in;
            FLAGS: if (data_valid_in) flags_q <= data_in[7:4];
            LO:    if (data_valid_in) lo_q    <= data_in;
            HI:    if (data_valid_in) hi_q    <= data_in;
            default: ;
         endcase
      end
   end

   // Done mask: a sprite is marked once its pixels are accepted, cleared per line
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         done_q <= '0;
      end else if (tclk_in) begin
         if (line_start_in)
            done_q <= '0;
         else if (state == PUSH && fifo_ready_in)
            done_q[win_q] <= 1'b1;
      end
   end

   // Address arithmetic and pixel decode from the latched sprite data
   always_comb begin
      oam_addr = OAM_BASE + {8'd0, num_q, 2'b00};
      if (tall_mode_in) begin
         tile_eff = {tile_q[7:1], 1'b0};
         row_eff  = flags_q[ATTR_YFLIP] ? (4'd15 - row_q) : row_q;
      end else begin
         tile_eff = tile_q;
         row_eff  = {1'b0, flags_q[ATTR_YFLIP] ? (3'd7 - row_q[2:0]) : row_q[2:0]};
      end
      row_base = VRAM_BASE + {4'd0, tile_eff, 4'd0} + {11'd0, row_eff, 1'b0};
      pix_raw  = '0;
      for (int k = 0; k < 8; k++) begin
         if (flags_q[ATTR_XFLIP])
            pix_raw[15-2*k -: 2] = {hi_q[k], lo_q[k]};
         else
            pix_raw[15-2*k -: 2] = {hi_q[7-k], lo_q[7-k]};
      end
      // Sprites partly off the left edge lose their first 8-X pixels
      clip_sh  = {4'd8 - {1'b0, x_q[2:0]}, 1'b0};
      pix_clip = (x_q < 8'd8) ? (pix_raw << clip_sh) : pix_raw;
   end

   // Outputs decoded from the current state
   always_comb begin
      addr_out          = '0;
      addr_valid_out    = 1'b0;
      push_valid_out    = 1'b0;
      push_pixels_out   = '0;
      push_palette_out  = 1'b0;
      push_priority_out = 1'b0;
      case (state)
         TILE: begin
            addr_out       = oam_addr + {14'd0, OAM_TILE_OFS};
            addr_valid_out = 1'b1;
         end
         FLAGS: begin
            addr_out       = oam_addr + {14'd0, OAM_FLAGS_OFS};
            addr_valid_out = 1'b1;
         end
         LO: begin
            addr_out       = row_base;
            addr_valid_out = 1'b1;
         end
         HI: begin
            addr_out       = row_base + 16'd1;
            addr_valid_out = 1'b1;
         end
         PUSH: begin
            push_valid_out    = 1'b1;
            push_pixels_out   = pix_clip;
            push_palette_out  = flags_q[ATTR_PAL];
            push_priority_out = flags_q[ATTR_PRIO];
         end
         default: ;
      endcase
   end

endmodule
